// File: rtl/div_if.sv
// Handshake and result bundle between the EX stage and the multi-cycle divider.
// The EX stage drives the master side; the divider implements the slave side.
interface div_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic [4:0]      reg_waddr_i;
    logic [XLEN-1:0] result_o;
    logic            ready_o;
    logic            reg_we_o;
    logic [4:0]      reg_waddr_o;
    logic            busy_o;
    logic            hold_flag_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, reg_waddr_i,
        input  result_o, ready_o, reg_we_o, reg_waddr_o, busy_o, hold_flag_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i,
        output result_o, ready_o, reg_we_o, reg_waddr_o, busy_o, hold_flag_o
    );
endinterface

// File: rtl/div_unit.sv
// RV32M restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Holds the pipeline while busy and strobes the result plus rd write for one cycle.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [1:0]      op_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] dvd_r, dvs_r, rem_r, quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic            neg_q_r, neg_r_r;
    logic [XLEN-1:0] result_r;
    logic            ready_r;
    logic [4:0]      waddr_r;

    logic            accept_s, signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s;
    logic [XLEN:0]   rem_ext_s, diff_s;
    logic            ge_s;
    logic [XLEN-1:0] rem_nxt_s, quo_nxt_s, calc_res_s, dz_res_s;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection; a zero divisor skips straight to DONE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    state_nxt_s = (bus.divisor_i == {XLEN{1'b0}}) ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_W'(XLEN - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand conditioning and one restoring step; the extra top bit keeps large divisors exact
    always_comb begin
        accept_s   = (state_r == IDLE) && bus.start_i;
        signed_s   = !bus.op_i[0];
        a_neg_s    = signed_s && bus.dividend_i[XLEN-1];
        b_neg_s    = signed_s && bus.divisor_i[XLEN-1];
        abs_a_s    = a_neg_s ? negate(bus.dividend_i) : bus.dividend_i;
        abs_b_s    = b_neg_s ? negate(bus.divisor_i) : bus.divisor_i;
        rem_ext_s  = {rem_r, dvd_r[XLEN-1]};
        diff_s     = rem_ext_s - {1'b0, dvs_r};
        ge_s       = !diff_s[XLEN];
        rem_nxt_s  = ge_s ? diff_s[XLEN-1:0] : rem_ext_s[XLEN-1:0];
        quo_nxt_s  = {quo_r[XLEN-2:0], ge_s};
        calc_res_s = op_r[1] ? (neg_r_r ? negate(rem_nxt_s) : rem_nxt_s)
                             : (neg_q_r ? negate(quo_nxt_s) : quo_nxt_s);
        dz_res_s   = bus.op_i[1] ? bus.dividend_i : {XLEN{1'b1}};
    end

    // Operand latch on accept and iteration datapath during CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 2'b00;
            rd_r    <= 5'd0;
            dvd_r   <= {XLEN{1'b0}};
            dvs_r   <= {XLEN{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            quo_r   <= {XLEN{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s) begin
            op_r    <= bus.op_i;
            rd_r    <= bus.reg_waddr_i;
            dvd_r   <= abs_a_s;
            dvs_r   <= abs_b_s;
            rem_r   <= {XLEN{1'b0}};
            quo_r   <= {XLEN{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
        end else if (state_r == CALC) begin
            dvd_r <= {dvd_r[XLEN-2:0], 1'b0};
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result/write-back registers are loaded on the edge into DONE and cleared otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {XLEN{1'b0}};
            ready_r  <= 1'b0;
            waddr_r  <= 5'd0;
        end else if (state_nxt_s == DONE) begin
            result_r <= (state_r == IDLE) ? dz_res_s : calc_res_s;
            ready_r  <= 1'b1;
            waddr_r  <= (state_r == IDLE) ? bus.reg_waddr_i : rd_r;
        end else begin
            result_r <= {XLEN{1'b0}};
            ready_r  <= 1'b0;
            waddr_r  <= 5'd0;
        end
    end

    assign bus.result_o    = result_r;
    assign bus.ready_o     = ready_r;
    assign bus.reg_we_o    = ready_r;
    assign bus.reg_waddr_o = waddr_r;
    assign bus.busy_o      = (state_r == CALC);
    // Hold drops in DONE so the pipeline advances on the edge that writes rd
    assign bus.hold_flag_o = accept_s || (state_r == CALC);
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_div_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    div_if #(.XLEN(32)) bus ();
    div_unit #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics using wide signed arithmetic (no overflow trap at 64 bits)
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, res;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        res = op[1] ? (sa % sb) : (sa / sb);
        return res[31:0];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_result"}, bus.result_o, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, bus.ready_o}, 32'd0);
        check_eq({tag, "_we"}, {31'd0, bus.reg_we_o}, 32'd0);
        check_eq({tag, "_waddr"}, {27'd0, bus.reg_waddr_o}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
    endtask

    // Launch one op at cycle 0; optionally pulse start_i with junk operands at cycles p1/p2
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int p1, input int p2);
        logic [31:0] exp_res;
        int exp_lat, hold_cnt, ready_cyc, extra_ready;
        exp_res     = ref_div(op, a, b);
        exp_lat     = (b == 32'd0) ? 1 : 33;
        hold_cnt    = 0;
        ready_cyc   = -1;
        extra_ready = 0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b; bus.reg_waddr_i = rd;
        #1;
        check_eq({tag, "_hold_c0"}, {31'd0, bus.hold_flag_o}, 32'd1);
        hold_cnt = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start_i = (k == p1) || (k == p2);
            if (bus.start_i) begin
                bus.op_i = 2'($urandom_range(0, 3));
                bus.dividend_i = $urandom;
                bus.divisor_i = $urandom_range(1, 1000);
                bus.reg_waddr_i = 5'($urandom_range(0, 31));
            end else begin
                bus.op_i = 2'b00; bus.dividend_i = 32'd0; bus.divisor_i = 32'd0; bus.reg_waddr_i = 5'd0;
            end
            #1;
            if (bus.hold_flag_o) hold_cnt++;
            if (bus.ready_o) begin
                if (ready_cyc < 0) begin
                    ready_cyc = k;
                    check_eq({tag, "_result"}, bus.result_o, exp_res);
                    check_eq({tag, "_waddr"}, {27'd0, bus.reg_waddr_o}, {27'd0, rd});
                    check_eq({tag, "_we"}, {31'd0, bus.reg_we_o}, 32'd1);
                end else begin
                    extra_ready++;
                end
            end else if (ready_cyc >= 0 && k == ready_cyc + 1) begin
                check_idle_outputs({tag, "_after"});
            end
        end
        check_eq({tag, "_latency"}, 32'(ready_cyc), 32'(exp_lat));
        check_eq({tag, "_hold_cycles"}, 32'(hold_cnt), 32'(exp_lat));
        check_eq({tag, "_extra_ready"}, 32'(extra_ready), 32'd0);
        check_eq({tag, "_busy_end"}, {31'd0, bus.busy_o}, 32'd0);
    endtask

    // Reset asserted mid-CALC must abort cleanly without a later ready pulse
    task automatic reset_mid_calc();
        int stray;
        stray = 0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 2'b01; bus.dividend_i = 32'd999; bus.divisor_i = 32'd4; bus.reg_waddr_i = 5'd9;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (k == 15) rst_n = 1'b0;
            if (k == 17) rst_n = 1'b1;
            #1;
            if (k == 15 || k == 16) begin
                check_idle_outputs($sformatf("rst_c%0d", k));
                check_eq($sformatf("rst_c%0d_hold", k), {31'd0, bus.hold_flag_o}, 32'd0);
            end
            if (k >= 15 && bus.ready_o) stray++;
        end
        check_eq("rst_no_ready", 32'(stray), 32'd0);
        check_eq("rst_state_idle", {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.op_i = 2'b00; bus.dividend_i = 32'd0; bus.divisor_i = 32'd0; bus.reg_waddr_i = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        check_eq("reset_hold", {31'd0, bus.hold_flag_o}, 32'd0);
        rst_n = 1'b1;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, -1, -1);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, -1, -1);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4, -1, -1);
        run_op("div_by0", 2'b00, 32'd123, 32'd0, 5'd6, -1, -1);
        run_op("remu_by0", 2'b11, 32'd123, 32'd0, 5'd7, -1, -1);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1, -1);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, -1, -1);
        run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11, -1, -1);
        run_op("ignore_start", 2'b01, 32'd50, 32'd5, 5'd12, 10, 33);
        reset_mid_calc();
        run_op("after_rst", 2'b01, 32'd1000, 32'd3, 5'd13, -1, -1);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 17);
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
